// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-port round-robin APB master.
// Optional feature macro: APB_ARB_TIMEOUT_EN (ACCESS-phase timeout abort).
package apb_arb_pkg;

    // APB master sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Requester indices
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    // Default number of ACCESS cycles allowed before an abort
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter. The grant is combinational from the
// eligible requests and the last-granted pointer; the pointer advances
// only when the master actually accepts a grant.
module apb_rr_arb
    import apb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       update,
    output logic       grant,
    output logic       any
);

    logic last;

    // Pick the requester that did not win last time when both are asking
    always_comb begin
        any   = |eligible;
        grant = 1'(REQ0);
        if (eligible[REQ0] && eligible[REQ1]) begin
            grant = ~last;
        end else if (eligible[REQ1]) begin
            grant = 1'(REQ1);
        end
    end

    // Remember the most recent winner; reset favours requester 0 on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'(REQ1);
        end else if (update) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-port APB master: arbitrates between two local requesters, runs the
// APB SETUP/ACCESS sequence for the winner and returns a registered
// completion strobe, read data and error flag to it.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- when defined, an ACCESS
// phase that sees no PREADY for TIMEOUT cycles is aborted with an error.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic [1:0]      req_i,
    input  logic [1:0]      req_write_i,
    input  logic [2*AW-1:0] req_addr_i,
    input  logic [2*DW-1:0] req_wdata_i,
    output logic [1:0]      ack_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic [AW-1:0]   PADDR,
    output logic            PSELx,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [DW-1:0]   PWDATA,
    input  logic            PREADY,
    input  logic            PSLVERR,
    input  logic [DW-1:0]   PRDATA
);

    apb_state_t state;
    apb_state_t next_state;
    logic [1:0] eligible;
    logic       arb_grant;
    logic       arb_any;
    logic       grant_idx;
    logic       start;
    logic       done;

    // A requester whose ack is showing this cycle is still dropping its request
    assign eligible = req_i & ~ack_o;

    apb_rr_arb u_arb (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .eligible (eligible),
        .update   (start),
        .grant    (arb_grant),
        .any      (arb_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          abort;

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    // Count ACCESS cycles without PREADY; restart at every SETUP
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and APB phase strobes
    always_comb begin
        next_state = state;
        PSELx      = 1'b0;
        PENABLE    = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        abort      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arb_any) begin
                    start      = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                PSELx      = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant and register the completion results
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            grant_idx <= 1'b0;
            ack_o     <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            ack_o <= '0;
            if (start) begin
                grant_idx <= arb_grant;
                PADDR     <= arb_grant ? req_addr_i[AW +: AW]  : req_addr_i[0 +: AW];
                PWDATA    <= arb_grant ? req_wdata_i[DW +: DW] : req_wdata_i[0 +: DW];
                PWRITE    <= arb_grant ? req_write_i[1]        : req_write_i[0];
            end
            if (done) begin
                ack_o[grant_idx] <= 1'b1;
                err_o            <= PSLVERR;
                if (!PWRITE) begin
                    rdata_o <= PRDATA;
                end
            end
`ifdef APB_ARB_TIMEOUT_EN
            if (abort) begin
                ack_o[grant_idx] <= 1'b1;
                err_o            <= 1'b1;
                rdata_o          <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: a cycle-by-cycle vector table for
// single transfers, wait states and errors, then hand-written sequences for
// round-robin alternation, the optional timeout (APB_ARB_TIMEOUT_EN) and
// reset in the middle of an ACCESS phase.
module tb_apb_arb_master;

    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] W0  = 32'hDEAD_BEEF;
    localparam logic [31:0] A1  = 32'h0000_0004;
    localparam logic [31:0] W1  = 32'h1111_1111;
    localparam logic [31:0] RD1 = 32'h1234_5678;
    localparam logic [31:0] RD2 = 32'hCAFE_F00D;
    localparam logic [31:0] RD3 = 32'h9999_0000;
    localparam int          NV  = 20;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_i;
    logic [1:0]  req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    int errors = 0;
    int checks = 0;

    // One clock cycle: inputs held during the cycle, outputs expected during it
    typedef struct {
        logic [1:0]  req;
        logic        rdy;
        logic        slv;
        logic [31:0] prd;
        logic        e_psel;
        logic        e_pen;
        logic [1:0]  e_ack;
        logic        chk;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
    } vec_t;

    vec_t vecs [NV];

    apb_arb_master #(.DW(32), .AW(32), .TIMEOUT(4)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .PADDR       (PADDR),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .PRDATA      (PRDATA)
    );

    // Free-running clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Hard stop in case a sequence never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input vec_t v);
        req_i   = v.req;
        PREADY  = v.rdy;
        PSLVERR = v.slv;
        PRDATA  = v.prd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    int  waited;
    int  access_cnt;
    bit  seen;

    // Main test sequence
    initial begin
        // Requester 0 writes, requester 1 reads; addresses/data stay fixed
        req_write_i = 2'b01;
        req_addr_i  = {A1, A0};
        req_wdata_i = {W1, W0};
        req_i       = 2'b00;
        PREADY      = 1'b1;
        PSLVERR     = 1'b0;
        PRDATA      = 32'h0;
        PRESETn     = 1'b0;

        //         req    rdy   slv   prd    psel  pen   ack    chk   err   rdata  paddr pwr   pwdata
        vecs[0]  = '{2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[6]  = '{2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[8]  = '{2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[9]  = '{2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[10] = '{2'b10, 1'b1, 1'b0, RD1,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[11] = '{2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, RD1,   A1,    1'b0, W1};
        vecs[12] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[13] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[14] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[15] = '{2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, RD1,   A0,    1'b1, W0};
        vecs[16] = '{2'b10, 1'b1, 1'b0, RD2,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A0,    1'b1, W0};
        vecs[17] = '{2'b10, 1'b1, 1'b0, RD2,   1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[18] = '{2'b10, 1'b1, 1'b0, RD2,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, A1,    1'b0, W1};
        vecs[19] = '{2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, RD2,   A1,    1'b0, W1};

        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        // Table: single write, 2-wait-state read, error then clean transfer
        for (int i = 0; i < NV; i++) begin
            @(negedge PCLK);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d psel", i),   32'(PSELx),   32'(vecs[i].e_psel));
            checkOutput($sformatf("row%0d penable", i), 32'(PENABLE), 32'(vecs[i].e_pen));
            checkOutput($sformatf("row%0d ack", i),    32'(ack_o),   32'(vecs[i].e_ack));
            checkOutput($sformatf("row%0d paddr", i),  PADDR,        vecs[i].e_paddr);
            checkOutput($sformatf("row%0d pwrite", i), 32'(PWRITE),  32'(vecs[i].e_pwrite));
            checkOutput($sformatf("row%0d pwdata", i), PWDATA,       vecs[i].e_pwdata);
            if (vecs[i].chk) begin
                checkOutput($sformatf("row%0d err", i),   32'(err_o), 32'(vecs[i].e_err));
                checkOutput($sformatf("row%0d rdata", i), rdata_o,    vecs[i].e_rdata);
            end
        end

        // Round robin: both requests held from reset, grants must alternate 0,1,0,1,0
        @(negedge PCLK);
        PRESETn = 1'b0;
        req_i   = 2'b00;
        @(negedge PCLK);
        PRESETn = 1'b1;
        req_i   = 2'b11;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = RD3;
        for (int k = 0; k < 5; k++) begin
            seen   = 1'b0;
            waited = 0;
            while (!seen && waited < 8) begin
                @(negedge PCLK);
                #1;
                if (ack_o != 2'b00) seen = 1'b1;
                else waited++;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("[TB] FAIL rr ack %0d: got no ack within 8 cycles, required one", k);
            end else begin
                checkOutput($sformatf("rr grant %0d", k), 32'(ack_o), (k % 2 == 0) ? 32'h1 : 32'h2);
                if (k == 4) req_i = 2'b00;
                @(negedge PCLK);
                #1;
                checkOutput($sformatf("rr ack single-cycle %0d", k), 32'(ack_o), 32'h0);
            end
        end
        checkOutput("rr last read data", rdata_o, RD3);

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout: slave never ready, abort after 4 ACCESS cycles with error
        PREADY     = 1'b0;
        req_i      = 2'b01;
        seen       = 1'b0;
        waited     = 0;
        access_cnt = 0;
        while (!seen && waited < 20) begin
            @(negedge PCLK);
            #1;
            if (ack_o != 2'b00) seen = 1'b1;
            else begin
                if (PENABLE) access_cnt++;
                waited++;
            end
        end
        req_i  = 2'b00;
        PREADY = 1'b1;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout ack: got no ack within 20 cycles, required one");
        end else begin
            checkOutput("timeout ack",           32'(ack_o),  32'h1);
            checkOutput("timeout err",           32'(err_o),  32'h1);
            checkOutput("timeout rdata",         rdata_o,     32'h0);
            checkOutput("timeout access cycles", access_cnt,  32'd4);
            checkOutput("timeout psel",          32'(PSELx),  32'h0);
        end
        @(negedge PCLK);
`endif

        // Reset in the middle of an ACCESS phase with the slave stalling
        req_i  = 2'b10;
        PREADY = 1'b0;
        waited = 0;
        while (!PENABLE && waited < 10) begin
            @(negedge PCLK);
            #1;
            waited++;
        end
        checkOutput("reset test reached access", 32'(PENABLE), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("async reset psel",    32'(PSELx),   32'h0);
        checkOutput("async reset penable", 32'(PENABLE), 32'h0);
        checkOutput("async reset ack",     32'(ack_o),   32'h0);
        checkOutput("async reset rdata",   rdata_o,      32'h0);
        checkOutput("async reset err",     32'(err_o),   32'h0);
        checkOutput("async reset paddr",   PADDR,        32'h0);
        @(negedge PCLK);
        req_i = 2'b00;
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            #1;
            checkOutput($sformatf("post reset idle psel %0d", c), 32'(PSELx), 32'h0);
            checkOutput($sformatf("post reset no ack %0d", c),    32'(ack_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
